// File: rtl/icb_reg_target_pkg.sv
// rtl/icb_reg_target_pkg.sv - shared widths and FSM state type for the ICB register target
package icb_reg_target_pkg;

    localparam int ICB_AW = 32;
    localparam int ICB_DW = 32;
    localparam int ICB_MW = ICB_DW / 8;
    localparam int LAT_CW = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RSP  = 2'd2
    } state_e;

endpackage

// File: rtl/icb_reg_bank.sv
// rtl/icb_reg_bank.sv - register storage with byte-masked write and indexed read mux
module icb_reg_bank
    import icb_reg_target_pkg::*;
#(
    parameter int NUM_REGS = 16,
    localparam int IDX_W   = $clog2(NUM_REGS)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_en_i,
    input  logic [IDX_W-1:0]           idx_i,
    input  logic [ICB_DW-1:0]          wdata_i,
    input  logic [ICB_MW-1:0]          wmask_i,
    output logic [ICB_DW-1:0]          rdata_o,
    output logic [NUM_REGS*ICB_DW-1:0] regs_o
);

    logic [ICB_DW-1:0] regs_q [NUM_REGS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_REGS; k++) begin
                regs_q[k] <= '0;
            end
        end else if (wr_en_i) begin
            for (int b = 0; b < ICB_MW; b++) begin
                if (wmask_i[b]) begin
                    regs_q[idx_i][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end
        end
    end

    assign rdata_o = regs_q[idx_i];

    for (genvar k = 0; k < NUM_REGS; k++) begin : g_flat
        assign regs_o[k*ICB_DW +: ICB_DW] = regs_q[k];
    end

endmodule

// File: rtl/icb_reg_target.sv
// rtl/icb_reg_target.sv - ICB register target: command decode, latency FSM and response register
module icb_reg_target
    import icb_reg_target_pkg::*;
#(
    parameter logic [ICB_AW-1:0] BASE_ADDR = 32'h1000_0000,
    parameter int                NUM_REGS  = 16,
    parameter int                RSP_LAT   = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       icb_cmd_valid,
    output logic                       icb_cmd_ready,
    input  logic [ICB_AW-1:0]          icb_cmd_addr,
    input  logic                       icb_cmd_read,
    input  logic [ICB_DW-1:0]          icb_cmd_wdata,
    input  logic [ICB_MW-1:0]          icb_cmd_wmask,
    output logic                       icb_rsp_valid,
    input  logic                       icb_rsp_ready,
    output logic                       icb_rsp_err,
    output logic [ICB_DW-1:0]          icb_rsp_rdata,
    output logic [NUM_REGS*ICB_DW-1:0] regs_o
);

    localparam int                IDX_W    = $clog2(NUM_REGS);
    localparam logic [ICB_AW-1:0] SPAN     = ICB_AW'(4 * NUM_REGS);
    localparam logic [LAT_CW-1:0] LAT_LOAD = LAT_CW'(RSP_LAT - 1);

    state_e              state_q, state_d;
    logic [LAT_CW-1:0]   cnt_q, cnt_d;
    logic                rsp_err_q, rsp_err_d;
    logic [ICB_DW-1:0]   rsp_rdata_q, rsp_rdata_d;

    logic [ICB_AW-1:0]   offset;
    logic                addr_hit;
    logic                cmd_hs;
    logic                rsp_hs;
    logic                wr_en;
    logic [ICB_DW-1:0]   bank_rdata;

    // Unsigned offset: addresses below BASE_ADDR wrap to huge values and miss.
    assign offset   = icb_cmd_addr - BASE_ADDR;
    assign addr_hit = (offset < SPAN) && (icb_cmd_addr[1:0] == 2'b00);

    assign icb_cmd_ready = (state_q == ST_IDLE);
    assign icb_rsp_valid = (state_q == ST_RSP);
    assign icb_rsp_err   = rsp_err_q;
    assign icb_rsp_rdata = rsp_rdata_q;

    assign cmd_hs = icb_cmd_valid & icb_cmd_ready;
    assign rsp_hs = icb_rsp_valid & icb_rsp_ready;
    assign wr_en  = cmd_hs & ~icb_cmd_read & addr_hit;

    icb_reg_bank #(
        .NUM_REGS (NUM_REGS)
    ) u_bank (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en_i (wr_en),
        .idx_i   (offset[IDX_W+1:2]),
        .wdata_i (icb_cmd_wdata),
        .wmask_i (icb_cmd_wmask),
        .rdata_o (bank_rdata),
        .regs_o  (regs_o)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rsp_err_d   = rsp_err_q;
        rsp_rdata_d = rsp_rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_hs) begin
                    rsp_err_d   = ~addr_hit;
                    rsp_rdata_d = (icb_cmd_read && addr_hit) ? bank_rdata : '0;
                    if (RSP_LAT == 1) begin
                        state_d = ST_RSP;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = LAT_LOAD;
                    end
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - LAT_CW'(1);
                if (cnt_q == LAT_CW'(1)) begin
                    state_d = ST_RSP;
                end
            end
            ST_RSP: begin
                if (rsp_hs) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

endmodule

// File: doc/icb_reg_target.md
ICB_REG_TARGET -- requirements
Module: icb_reg_target

Interface
REQ-001 Parameter BASE_ADDR, default 32'h1000_0000, byte address of register 0.
REQ-002 Parameter NUM_REGS, default 16, number of 32-bit registers (power of two, 2..256).
REQ-003 Parameter RSP_LAT, default 1, cycles from cmd handshake to rsp_valid (1..15).
REQ-004 The block SHALL use one clock; reset is asynchronous and active-low; ports are named clk and rst_n.
REQ-005 clk  input  1  block clock.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 icb_cmd_valid  input  1  initiator command valid.
REQ-008 icb_cmd_ready  output  1  target accepts command.
REQ-009 icb_cmd_addr  input  32  byte address.
REQ-010 icb_cmd_read  input  1  1 = read, 0 = write.
REQ-011 icb_cmd_wdata  input  32  write data.
REQ-012 icb_cmd_wmask  input  4  byte write enables, bit n covers wdata[8n+7:8n].
REQ-013 icb_rsp_valid  output  1  response valid.
REQ-014 icb_rsp_ready  input  1  initiator accepts response.
REQ-015 icb_rsp_err  output  1  response error flag.
REQ-016 icb_rsp_rdata  output  32  read data.
REQ-017 regs_o  output  NUM_REGS*32  flattened register contents, register k at bits [32k+31:32k].

Function
REQ-018 Control SHALL be an FSM with states IDLE, WAIT, RSP.
REQ-019 icb_cmd_ready SHALL be 1 only in IDLE; cmd handshake = valid & ready.
REQ-020 On cmd handshake: IDLE -> RSP if RSP_LAT==1, else IDLE -> WAIT with latency counter loaded to RSP_LAT-1.
REQ-021 WAIT SHALL decrement counter each cycle and go to RSP when counter reaches 1 (rsp_valid exactly RSP_LAT cycles after handshake).
REQ-022 icb_rsp_valid SHALL be 1 only in RSP and held with stable err/rdata until icb_rsp_ready; RSP -> IDLE on rsp handshake.
REQ-023 Single outstanding transaction; a command presented outside IDLE SHALL stall (no drop, no duplicate).
REQ-024 Address hit: addr in [BASE_ADDR, BASE_ADDR+4*NUM_REGS) and addr[1:0]==0; index = (addr-BASE_ADDR)>>2, computed in 32-bit modulo arithmetic (no wrap aliasing below BASE_ADDR).
REQ-025 Write hit SHALL update only masked bytes of the indexed register in the handshake cycle; wmask 0 is a legal no-op write, err=0.
REQ-026 Read hit SHALL capture the indexed register at handshake into the response data register; wmask ignored.
REQ-027 Miss (out of range or misaligned) SHALL set err=1, rdata=0, no register change.
REQ-028 Write response rdata SHALL be 0.
REQ-029 Peak throughput SHALL be one transaction per RSP_LAT+1 cycles with rsp_ready held 1.
REQ-030 regs_o SHALL reflect a write from the cycle after its handshake.

Reset
REQ-031 rst_n low SHALL immediately force FSM to IDLE, counter 0, all registers 0, icb_rsp_valid 0, icb_rsp_err 0, icb_rsp_rdata 0, regs_o 0.
REQ-032 Reset mid-transaction SHALL abandon the pending response; icb_cmd_ready SHALL be 1 in the first cycle after rst_n deasserts.

Structure
REQ-033 Package icb_reg_target_pkg SHALL hold the FSM state enum, ICB data/mask width constants, and latency counter width (4 bits).
REQ-034 Register storage with byte-masked write and read mux SHALL be one sub-module, icb_reg_bank; FSM, decode and response register stay in icb_reg_target.

Verification
REQ-035 Write 0xDEADBEEF, mask 4'hF, to BASE+0x8, then read BASE+0x8 -> read rsp rdata 0xDEADBEEF, err 0; regs_o[95:64]=0xDEADBEEF.
REQ-036 Reg 3 = 0x11223344, write 0xAABBCCDD mask 4'b0101 to BASE+0xC -> read returns 0x11BB33DD.
REQ-037 Read BASE+0x40 (NUM_REGS=16), read BASE+0x2, write BASE-4 -> each err 1, rdata 0, regs_o unchanged.
REQ-038 RSP_LAT=3, rsp_ready held 0 for 5 cycles after rsp_valid -> rsp_valid rises 3 cycles after handshake, stays 1 with stable data, cmd_ready 0 throughout, then 1 the cycle after rsp handshake.
REQ-039 Back-to-back cmd_valid with rsp_ready=1, RSP_LAT=1 -> handshakes every 2 cycles, responses in order, no loss.
REQ-040 Assert rst_n low while in WAIT after a write to reg 1 -> rsp_valid 0 immediately, regs_o all 0, cmd_ready 1 first cycle after release.
